// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: FSM state, grant and memory-direction encodings shared by the data-memory arbiter.
package dmem_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_CORE_RD, ARB_LD_WR} arb_state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_CORE, GNT_LD} gnt_t;
    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;
endpackage

// File: rtl/dmem_arbiter_ld_byte_packer.sv
// ld_byte_packer: packs in-order loader bytes little-endian into one word buffer and flags out-of-order bytes.
module ld_byte_packer #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_byte,
    input  logic          clr_full,
    output logic          ld_ready,
    output logic          ld_err,
    output logic          wbuf_full,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata
);
    logic       released;
    logic [1:0] bcnt;
    logic       accept;

    assign ld_ready = released && !wbuf_full;
    assign accept   = ld_valid && ld_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            released  <= 1'b0;
            bcnt      <= '0;
            wbuf_full <= 1'b0;
            ld_err    <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else begin
            released <= 1'b1;
            if (clr_full) wbuf_full <= 1'b0;
            if (accept) begin
                wdata[8*bcnt +: 8] <= ld_byte;
                bcnt <= bcnt + 2'd1;
                if (ld_addr[1:0] != bcnt) ld_err <= 1'b1;
                if (bcnt == 2'd3) begin
                    wbuf_full <= 1'b1;
                    waddr     <= {2'b00, ld_addr[AW-1:2]};
                end
            end
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: one memory access per cycle shared between the core memory stage and the byte loader.
// Define DMEM_ARB_STARVE_EN to let a loader word that waited STARVE_MAX cycles preempt the core.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
`ifdef DMEM_ARB_STARVE_EN
    , parameter int STARVE_MAX = 8
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_rw,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_stall,
    output logic [DW-1:0] core_rdata,
    output logic          core_rvalid,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_byte,
    output logic          ld_err,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    arb_state_t    state, nxt;
    gnt_t          gnt;
    logic          wbuf_full, preempt;
    logic [AW-1:0] ld_waddr, last_addr;
    logic [DW-1:0] ld_wdata, last_wdata;

    ld_byte_packer #(.AW(AW), .DW(DW)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_byte   (ld_byte),
        .clr_full  (gnt == GNT_LD),
        .ld_ready  (ld_ready),
        .ld_err    (ld_err),
        .wbuf_full (wbuf_full),
        .waddr     (ld_waddr),
        .wdata     (ld_wdata)
    );

`ifdef DMEM_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    assign preempt = wbuf_full && starve_cnt == SW'(STARVE_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starve_cnt <= '0;
        else if (gnt == GNT_LD) starve_cnt <= '0;
        else if (wbuf_full && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            last_addr  <= '0;
            last_wdata <= '0;
        end else begin
            state <= nxt;
            if (mem_en) begin
                last_addr  <= mem_addr;
                last_wdata <= mem_wdata;
            end
        end
    end

    // Grant is forced off while reset is held so every output reads zero immediately.
    always_comb begin
        gnt = !reset ? GNT_NONE : preempt ? GNT_LD : core_req ? GNT_CORE : wbuf_full ? GNT_LD : GNT_NONE;
        nxt = (gnt == GNT_CORE && core_rw == MEM_RD) ? ARB_CORE_RD : gnt == GNT_LD ? ARB_LD_WR : ARB_IDLE;
    end

    always_comb begin
        core_stall  = reset && core_req && gnt != GNT_CORE;
        core_rvalid = state == ARB_CORE_RD;
        core_rdata  = core_rvalid ? mem_rdata : '0;
        mem_en      = gnt != GNT_NONE;
        mem_rw      = gnt == GNT_CORE ? core_rw : MEM_WR;
        mem_addr    = gnt == GNT_CORE ? core_addr : gnt == GNT_LD ? ld_waddr : last_addr;
        mem_wdata   = gnt == GNT_CORE ? core_wdata : gnt == GNT_LD ? ld_wdata : last_wdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed scoreboard bench for dmem_arbiter with a behavioural memory model.
module tb_dmem_arbiter;
    logic        clk, reset, core_req, core_rw, core_stall, core_rvalid;
    logic [9:0]  core_addr, ld_addr, mem_addr;
    logic [31:0] core_wdata, core_rdata, mem_wdata, mem_rdata;
    logic        ld_valid, ld_ready, ld_err, mem_en, mem_rw;
    logic [7:0]  ld_byte;

    logic [31:0] ram [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] rd_q [$];
    logic [41:0] ld_q [$];
    int checks = 0, errors = 0, cyc = 0, stall_cnt = 0;
    int ld_wr_cnt = 0, ld_wr_cyc = -1, acc_cyc = -1, rv_run = 0, rv_max = 0;
    int pos = 0;
    bit exp_err = 0;
    logic [31:0] cur_word = '0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset), .core_req(core_req), .core_rw(core_rw), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_stall(core_stall), .core_rdata(core_rdata),
        .core_rvalid(core_rvalid), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_byte(ld_byte), .ld_err(ld_err), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (mem_en) begin
            if (mem_rw) mem_rdata <= ram[mem_addr];
            else ram[mem_addr] <= mem_wdata;
        end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d limit=20000", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected read data and loader words as the DUT presents them.
    always @(negedge clk) begin
        rv_run = core_rvalid ? rv_run + 1 : 0;
        if (rv_run > rv_max) rv_max = rv_run;
        if (reset) begin
            if (core_rvalid) begin
                if (rd_q.size() == 0) chk("rvalid_unexpected", 1, 0);
                else chk("core_rdata", core_rdata, rd_q.pop_front());
            end
            if (mem_en && !mem_rw && !(core_req && !core_stall)) begin
                ld_wr_cnt++;
                ld_wr_cyc = cyc;
                if (ld_q.size() == 0) chk("ld_write_unexpected", {mem_addr, mem_wdata}, 0);
                else chk("ld_write", {mem_addr, mem_wdata}, ld_q.pop_front());
            end
        end
    end

    task automatic core_op(input logic rw, input logic [9:0] a, input logic [31:0] d);
        bit done = 0;
        core_req = 1; core_rw = rw; core_addr = a; core_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!core_stall) begin
                done = 1;
                chk("core_grant_en", mem_en, 1);
                chk("core_grant_rw", mem_rw, rw);
                chk("core_grant_addr", mem_addr, a);
                if (rw) rd_q.push_back(ref_mem[a]);
                else begin
                    chk("core_wr_data", mem_wdata, d);
                    ref_mem[a] = d;
                end
            end else stall_cnt++;
            @(posedge clk); #1;
        end
        if (!done) chk("core_grant_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [9:0] a, input logic [7:0] b);
        bit done = 0;
        ld_valid = 1; ld_addr = a; ld_byte = b;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (ld_ready) begin
                done = 1;
                acc_cyc = cyc;
                if (a[1:0] != 2'(pos)) exp_err = 1;
                cur_word[8*pos +: 8] = b;
                if (pos == 3) ld_q.push_back({2'b00, a[9:2], cur_word});
                pos = (pos + 1) % 4;
            end
            @(posedge clk); #1;
        end
        ld_valid = 0;
        if (!done) chk("ld_accept_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_core_stall"}, core_stall, 0);
        chk({tag, "_core_rvalid"}, core_rvalid, 0);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_ld_err"}, ld_err, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_rw"}, mem_rw, 0);
        chk({tag, "_core_rdata"}, core_rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk); chk("ready_before_edge", ld_ready, 0);
        @(negedge clk); chk("ready_after_edge", ld_ready, 1);
        chk("ld_err_after_reset", ld_err, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base, drop;
        reset = 0; core_req = 0; core_rw = 0; core_addr = '0; core_wdata = '0;
        ld_valid = 0; ld_addr = '0; ld_byte = '0;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 32'hA5000000 ^ (i * 32'h00010203);
            ref_mem[i] = ram[i];
        end
        ram[10'h010] = 32'hDEADBEEF;
        ref_mem[10'h010] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        release_reset();

        core_op(1, 10'h010, 0);
        core_req = 0;
        @(negedge clk);
        chk("rd_rvalid", core_rvalid, 1);
        chk("rd_data_const", core_rdata, 32'hDEADBEEF);
        chk("rd_no_stall", stall_cnt, 0);
        @(posedge clk); #1;

        rv_max = 0;
        core_op(1, 10'h001, 0);
        core_op(1, 10'h002, 0);
        core_req = 0;
        repeat (3) @(posedge clk); #1;
        chk("b2b_rvalid_run", rv_max, 2);

        send_byte(10'h020, 8'h11); send_byte(10'h021, 8'h22);
        send_byte(10'h022, 8'h33); send_byte(10'h023, 8'h44);
        @(negedge clk);
        chk("pack_ready_low", ld_ready, 0);
        chk("pack_mem_en", mem_en, 1);
        chk("pack_mem_addr", mem_addr, 10'h008);
        chk("pack_mem_wdata", mem_wdata, 32'h44332211);
        @(negedge clk);
        chk("pack_ready_back", ld_ready, 1);
        @(posedge clk); #1;

        send_byte(10'h040, 8'hA1); send_byte(10'h042, 8'hA2);
        @(negedge clk);
        chk("order_err_set", ld_err, exp_err);
        chk("order_err_const", ld_err, 1);
        @(posedge clk); #1;
        send_byte(10'h042, 8'hA3); send_byte(10'h043, 8'hA4);
        repeat (3) @(posedge clk); #1;
        chk("order_err_sticky", ld_err, 1);

        send_byte(10'h180, 8'hE1); send_byte(10'h181, 8'hE2);
        core_req = 1; core_rw = 1; core_addr = 10'h200;
        reset = 0;
        #1;
        chk_all_zero("midreset");
        pos = 0; exp_err = 0;
        repeat (2) @(posedge clk); #1;
        core_req = 0;
        release_reset();
        send_byte(10'h184, 8'h55); send_byte(10'h185, 8'h66);
        send_byte(10'h186, 8'h77); send_byte(10'h187, 8'h88);
        @(negedge clk);
        chk("fresh_word", mem_wdata, 32'h88776655);
        @(posedge clk); #1;

        stall_cnt = 0;
        base = ld_wr_cnt;
        fork
            for (int i = 0; i < 20; i++) core_op(1, 10'h300 + 10'(i), 0);
            begin
                send_byte(10'h1F0, 8'hC0); send_byte(10'h1F1, 8'hC1);
                send_byte(10'h1F2, 8'hC2); send_byte(10'h1F3, 8'hC3);
            end
        join
`ifdef DMEM_ARB_STARVE_EN
        chk("starve_write_count", ld_wr_cnt - base, 1);
        chk("starve_latency", ld_wr_cyc - acc_cyc, 9);
        chk("starve_stall_cycles", stall_cnt, 1);
        core_req = 0;
`else
        chk("strict_no_ld_write", ld_wr_cnt - base, 0);
        chk("strict_no_stall", stall_cnt, 0);
        core_req = 0;
        drop = cyc;
        repeat (3) @(posedge clk); #1;
        chk("strict_write_after_drop", ld_wr_cnt - base, 1);
        chk("strict_write_cycle", ld_wr_cyc, drop);
`endif
        repeat (2) @(posedge clk); #1;

        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        core_req = 0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    core_op(1'($urandom_range(0, 1)), 10'($urandom_range(256, 1023)), $urandom);
                end
                core_req = 0;
            end
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1;
                end
                send_byte(10'h100 + 10'(i), 8'($urandom));
            end
        join
        for (int i = 0; i < 30 && (rd_q.size() != 0 || ld_q.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        chk("drain_rd_q", rd_q.size(), 0);
        chk("drain_ld_q", ld_q.size(), 0);
        chk("random_ld_err", ld_err, exp_err);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
